stream_upsize: RTL and testbench

Narrow-to-wide stream packer: gathers T_DATA_RATIO consecutive narrow beats of T_DATA_WIDTH bits into one wide word of T_DATA_RATIO lanes, with a per-lane keep mask and packet-end flag. It is the receive-side counterpart of stream_downsize. It sits where a serialized narrow stream must be restored to the wide datapath. Both sides use valid/ready handshakes with last.

---
 rtl/stream_upsize.sv | 124 ++++++++++++
 tb/tb_stream_upsize.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsize.sv
// stream_upsize: narrow-to-wide stream packer.
// Gathers up to T_DATA_RATIO narrow beats into one wide word of T_DATA_RATIO lanes.
// Lane 0 holds the first beat of the word.
// A word is closed either when every lane is filled or when a beat carries last.
// Lanes that were never written read as zero, and their keep bits are zero.
module stream_upsize #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,

    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
    output logic [T_DATA_RATIO-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    // The lane counter is at least 1 bit wide, so that a degenerate ratio still elaborates.
    localparam int LANE_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(T_DATA_RATIO - 1);

    logic [LANE_W-1:0]       r_lane_q;
    logic [T_DATA_RATIO-1:0] r_acc_keep;
    logic [T_DATA_RATIO-1:0] r_out_keep;
    logic                    r_out_last;
    logic                    r_out_valid;

    logic [T_DATA_RATIO-1:0] w_lane_sel;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic                    w_complete;

    // The upstream side may advance whenever the output register is empty
    // or is being emptied in this cycle.
    // This is the only combinational path, and it runs from m_ready_i.
    assign s_ready_o  = !rst && (!r_out_valid || m_ready_i);
    assign w_in_fire  = s_valid_i && s_ready_o;
    assign w_out_fire = r_out_valid && m_ready_i;
    assign w_complete = w_in_fire && ((r_lane_q == LAST_LANE) || s_last_i);

    assign m_keep_o  = r_out_keep;
    assign m_last_o  = r_out_last;
    assign m_valid_o = r_out_valid;

    generate
        for (genvar gi = 0; gi < T_DATA_RATIO; gi++) begin : g_lane
            logic [T_DATA_WIDTH-1:0] r_acc_lane;
            logic [T_DATA_WIDTH-1:0] r_out_lane;
            logic [T_DATA_WIDTH-1:0] w_word_lane;

            assign w_lane_sel[gi] = (r_lane_q == LANE_W'(gi));
            // A completing beat goes directly into the output word.
            // It never passes through the accumulator.
            assign w_word_lane    = w_lane_sel[gi] ? s_data_i : r_acc_lane;
            assign m_data_o[gi]   = r_out_lane;

            // Accumulation lane: capture the beat addressed to this lane.
            // Clear the lane when the word closes, so that unused lanes of the next word read as zero.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc_lane <= '0;
                end else if (w_complete) begin
                    r_acc_lane <= '0;
                end else if (w_in_fire && w_lane_sel[gi]) begin
                    r_acc_lane <= s_data_i;
                end
            end

            // Output lane: load only when a word closes.
            // The lane holds its value while the word waits downstream.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_lane <= '0;
                end else if (w_complete) begin
                    r_out_lane <= w_word_lane;
                end
            end
        end
    endgenerate

    // Lane counter: advance on each accepted beat, and wrap to lane 0 when the word closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_q <= '0;
        end else if (w_in_fire) begin
            r_lane_q <= w_complete ? '0 : (r_lane_q + LANE_W'(1));
        end
    end

    // Accumulated keep mask: set one bit per accepted beat, and start empty for each new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_keep <= '0;
        end else if (w_complete) begin
            r_acc_keep <= '0;
        end else if (w_in_fire) begin
            r_acc_keep <= r_acc_keep | w_lane_sel;
        end
    end

    // Output control: load on completion; this also replaces a word taken in the same cycle.
    // Otherwise drop valid once the word is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_keep  <= '0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_last  <= s_last_i;
            r_out_keep  <= r_acc_keep | w_lane_sel;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_upsize.sv
// Testbench for stream_upsize: directed scenarios, followed by a randomized run.
// The randomized run checks the output against a packet-level reassembly model.
module tb_stream_upsize;

    localparam int W = 8;
    localparam int R = 4;

    typedef struct packed {
        logic [W*R-1:0] data;
        logic [R-1:0]   keep;
        logic           last;
    } word_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   s_data_i;
    logic           s_last_i;
    logic           s_valid_i;
    logic           s_ready_o;
    logic [W-1:0]   m_data_o [R-1:0];
    logic [R-1:0]   m_keep_o;
    logic           m_last_o;
    logic           m_valid_o;
    logic           m_ready_i;

    int tests_run    = 0;
    int tests_failed = 0;

    logic           mon_en = 1'b0;
    logic [W:0]     in_q[$];
    word_t          out_q[$];

    stream_upsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_keep_o  (m_keep_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [W*R-1:0] out_word();
        logic [W*R-1:0] w;
        for (int i = 0; i < R; i++) w[i*W +: W] = m_data_o[i];
        return w;
    endfunction

    // At the falling edge, record what the next rising edge will transfer.
    // This covers both the input side and the output side.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (s_valid_i && s_ready_o) in_q.push_back({s_last_i, s_data_i});
            if (m_valid_o && m_ready_i) out_q.push_back('{data: out_word(), keep: m_keep_o, last: m_last_o});
        end
    end

    // Offer one beat, and return just after the edge that accepted it.
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int  n   = 0;
        logic acc = 1'b0;
        s_data_i  = d;
        s_last_i  = l;
        s_valid_i = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_ready_o;
            @(posedge clk); #1;
            n++;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        if (!acc) begin
            tests_run++; tests_failed++;
            $display("FAIL send_beat_timeout: beat %h not accepted, required acceptance within 200 cycles", d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b0 || m_last_o !== 1'b0 || m_keep_o !== '0 || out_word() !== '0 || s_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b last=%b keep=%b data=%h ready=%b, required all 0",
                     m_valid_o, m_last_o, m_keep_o, out_word(), s_ready_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (s_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: s_ready_o=%b, required 1", s_ready_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_word();
        m_ready_i = 1'b1;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b1);
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b1 || out_word() !== 32'h44332211 || m_keep_o !== 4'b1111 || m_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_word: valid=%b data=%h keep=%b last=%b, required 1 44332211 1111 1",
                     m_valid_o, out_word(), m_keep_o, m_last_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_word_one_cycle: valid=%b, required 0", m_valid_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_short_packet();
        m_ready_i = 1'b1;
        send_beat(8'hA1, 1'b0);
        send_beat(8'hA2, 1'b1);
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b1 || out_word() !== 32'h0000A2A1 || m_keep_o !== 4'b0011 || m_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL short_packet_2: valid=%b data=%h keep=%b last=%b, required 1 0000a2a1 0011 1",
                     m_valid_o, out_word(), m_keep_o, m_last_o);
        end
        @(posedge clk); #1;
        send_beat(8'hB1, 1'b1);
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b1 || out_word() !== 32'h000000B1 || m_keep_o !== 4'b0001 || m_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL short_packet_1: valid=%b data=%h keep=%b last=%b, required 1 000000b1 0001 1",
                     m_valid_o, out_word(), m_keep_o, m_last_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_long_packet();
        m_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) send_beat(W'(i), 1'b0);
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b1 || out_word() !== 32'h04030201 || m_keep_o !== 4'b1111 || m_last_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_packet_w1: valid=%b data=%h keep=%b last=%b, required 1 04030201 1111 0",
                     m_valid_o, out_word(), m_keep_o, m_last_o);
        end
        @(posedge clk); #1;
        send_beat(8'h05, 1'b0);
        send_beat(8'h06, 1'b1);
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b1 || out_word() !== 32'h00000605 || m_keep_o !== 4'b0011 || m_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL long_packet_w2: valid=%b data=%h keep=%b last=%b, required 1 00000605 0011 1",
                     m_valid_o, out_word(), m_keep_o, m_last_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        m_ready_i = 1'b1;
        send_beat(8'hE1, 1'b0);
        send_beat(8'hE2, 1'b0);
        send_beat(8'hE3, 1'b0);
        send_beat(8'hE4, 1'b1);
        m_ready_i = 1'b0;
        s_data_i  = 8'hF1;
        s_last_i  = 1'b0;
        s_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (m_valid_o !== 1'b1 || out_word() !== 32'hE4E3E2E1 || m_keep_o !== 4'b1111 ||
                m_last_o !== 1'b1 || s_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: valid=%b data=%h keep=%b last=%b ready=%b, required 1 e4e3e2e1 1111 1 0",
                         c, m_valid_o, out_word(), m_keep_o, m_last_o, s_ready_o);
            end
            @(posedge clk); #1;
        end
        m_ready_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_ready_o !== 1'b1 || m_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release: ready=%b valid=%b, required 1 1", s_ready_o, m_valid_o);
        end
        @(posedge clk); #1;
        s_valid_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_taken: valid=%b, required 0", m_valid_o);
        end
        @(posedge clk); #1;
        send_beat(8'hF2, 1'b1);
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b1 || out_word() !== 32'h0000F2F1 || m_keep_o !== 4'b0011 || m_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_no_dup: valid=%b data=%h keep=%b last=%b, required 1 0000f2f1 0011 1",
                     m_valid_o, out_word(), m_keep_o, m_last_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        m_ready_i = 1'b1;
        send_beat(8'hC1, 1'b0);
        send_beat(8'hC2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_ready: s_ready_o=%b, required 0", s_ready_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b0 || m_last_o !== 1'b0 || m_keep_o !== '0 || out_word() !== '0 || s_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: valid=%b last=%b keep=%b data=%h ready=%b, required 0 0 0000 0 1",
                     m_valid_o, m_last_o, m_keep_o, out_word(), s_ready_o);
        end
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send_beat(W'(8'hD0 + i), i == 4);
        @(negedge clk);
        tests_run++;
        if (m_valid_o !== 1'b1 || out_word() !== 32'hD4D3D2D1 || m_keep_o !== 4'b1111 || m_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_word: valid=%b data=%h keep=%b last=%b, required 1 d4d3d2d1 1111 1",
                     m_valid_o, out_word(), m_keep_o, m_last_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic           prev_stall = 1'b0;
        word_t          prev_word;
        word_t          exp_q[$];
        word_t          acc;
        int             lane;
        in_q.delete();
        out_q.delete();
        mon_en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            s_valid_i = ($urandom_range(99) < 80);
            s_last_i  = ($urandom_range(99) < 30);
            s_data_i  = W'($urandom);
            m_ready_i = $urandom_range(1);
            @(negedge clk);
            if (prev_stall) begin
                tests_run++;
                if (m_valid_o !== 1'b1 || out_word() !== prev_word.data || m_keep_o !== prev_word.keep ||
                    m_last_o !== prev_word.last) begin
                    tests_failed++;
                    $display("FAIL random_stall_stable cycle %0d: valid=%b data=%h keep=%b last=%b, required 1 %h %b %b",
                             c, m_valid_o, out_word(), m_keep_o, m_last_o, prev_word.data, prev_word.keep, prev_word.last);
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_word  = '{data: out_word(), keep: m_keep_o, last: m_last_o};
            @(posedge clk); #1;
        end
        // Close any open packet, then let the final word drain.
        m_ready_i = 1'b1;
        send_beat(8'h5A, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;

        // Reference model: split the accepted beat stream into words.
        // A word ends at R beats or at a last beat; the lane index restarts at 0 for each word.
        acc  = '0;
        lane = 0;
        foreach (in_q[i]) begin
            acc.data[lane*W +: W] = in_q[i][W-1:0];
            acc.keep[lane]        = 1'b1;
            if (lane == R-1 || in_q[i][W]) begin
                acc.last = in_q[i][W];
                exp_q.push_back(acc);
                acc  = '0;
                lane = 0;
            end else begin
                lane++;
            end
        end

        tests_run++;
        if (out_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL random_word_count: got %0d words, required %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            tests_run++;
            if (out_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL random_word[%0d]: data=%h keep=%b last=%b, required %h %b %b",
                         i, out_q[i].data, out_q[i].keep, out_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_packet();
        test_long_packet();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
